car_state_ctrl: RTL

Driving-state controller for the simulated car. Turns debounced driver controls (power button, throttle, clutch, brake, reverse lever, turn switches) into the 2-bit car state and qualified turn requests. The car indicator-light stage downstream consumes these directly. Purely synchronous, single clock domain; all outputs registered.

---
 rtl/car_state_ctrl.sv | 67 ++++++
 1 files changed

// File: rtl/car_state_ctrl.sv
// car_state_ctrl: driving-state FSM that turns driver controls into car state, gear and qualified turn requests.
// Optional idle auto power-off in NOT_STARTING is enabled by defining CAR_AUTO_POWEROFF_EN.
module car_state_ctrl #(
  parameter int POWER_HOLD_CYCLES   = 100_000_000,
  parameter int IDLE_TIMEOUT_CYCLES = 500_000_000,
  parameter int CNT_W               = 32
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       power_on,
  input  logic       power_off,
  input  logic       throttle,
  input  logic       clutch,
  input  logic       brake,
  input  logic       reverse_sw,
  input  logic       turn_left_sw,
  input  logic       turn_right_sw,
  output logic [1:0] state,
  output logic       turn_left,
  output logic       turn_right,
  output logic       reverse_gear
);
  typedef enum logic [1:0] {OFF = 2'b00, NOT_STARTING = 2'b01, STARTING = 2'b11, MOVING = 2'b10} state_t;
  localparam logic [CNT_W-1:0] HOLD_MAX = CNT_W'(POWER_HOLD_CYCLES - 1);
  state_t cur, nxt;
  logic [CNT_W-1:0] hold_cnt;
  logic idle, timeout;
  assign idle  = ~|{throttle, clutch, brake, power_on, turn_left_sw, turn_right_sw};
  assign state = cur;
`ifdef CAR_AUTO_POWEROFF_EN
  localparam logic [CNT_W-1:0] IDLE_MAX = CNT_W'(IDLE_TIMEOUT_CYCLES - 1);
  logic [CNT_W-1:0] idle_cnt;
  assign timeout = idle && idle_cnt == IDLE_MAX;
  always_ff @(posedge clk)
    if (!rst_n) idle_cnt <= '0;
    else idle_cnt <= (cur == NOT_STARTING && nxt == NOT_STARTING && idle) ? idle_cnt + CNT_W'(idle_cnt != '1) : '0;
`else
  assign timeout = idle && IDLE_TIMEOUT_CYCLES < 0;
`endif
  always_comb begin
    nxt = cur;
    case (cur)
      OFF:          nxt = (power_on && hold_cnt == HOLD_MAX) ? NOT_STARTING : OFF;
      NOT_STARTING: nxt = ((throttle && !clutch) || timeout) ? OFF : (throttle && clutch && !brake) ? STARTING : NOT_STARTING;
      STARTING:     nxt = brake ? NOT_STARTING : (throttle && !clutch) ? MOVING : STARTING;
      MOVING:       nxt = (reverse_sw != reverse_gear && !clutch) ? OFF : brake ? NOT_STARTING : (!throttle || clutch) ? STARTING : MOVING;
      default:      nxt = OFF;
    endcase
    if (power_off) nxt = OFF;
  end
  // turn outputs use nxt so they line up with the state they belong to
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cur          <= OFF;
      hold_cnt     <= '0;
      turn_left    <= 1'b0;
      turn_right   <= 1'b0;
      reverse_gear <= 1'b0;
    end else begin
      cur          <= nxt;
      hold_cnt     <= (cur == OFF && nxt == OFF && power_on && !power_off) ? hold_cnt + CNT_W'(hold_cnt != '1) : '0;
      reverse_gear <= (nxt == OFF && cur != OFF) ? 1'b0 : (cur == MOVING && !clutch) ? reverse_gear : reverse_sw;
      turn_left    <= nxt[1] && turn_left_sw && !turn_right_sw;
      turn_right   <= nxt[1] && turn_right_sw && !turn_left_sw;
    end
  end
endmodule
